blob_frame_sequencer: RTL and testbench
=======================================

# blob_frame_sequencer

Frame-aligned consumer of the grayscale start level driven by the VGA/blob sync controller. It turns the `i_grayscale_start` level plus `i_VGA_VSYNC` into whole-frame processing windows. Inside each window it counts accepted pixels into x/y coordinates, and it reports frame start, frame done, frame count and pixel-count errors to the grayscale/blob pipeline. It sits between the sync controller and the per-pixel blob datapath. It guarantees that the datapath only ever sees complete frames.

## Interface
Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- FRAME_CNT_W, 16: width of the frame counter.
- VSYNC_ACTIVE_LOW, 1: 1 means the frame boundary is the falling edge of i_VGA_VSYNC; 0 means the rising edge.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_grayscale_start  in  1  processing-enable level from the sync controller.
- i_VGA_VSYNC  in  1  raw VGA vertical sync.
- i_pix_valid  in  1  one active pixel presented this cycle.
- o_pix_en  out  1  registered pixel accept for the datapath.
- o_pix_x  out  10  x coordinate of the pixel flagged by o_pix_en.
- o_pix_y  out  10  y coordinate of the pixel flagged by o_pix_en.
- o_frame_start  out  1  one-cycle pulse at the first boundary of a processed frame.
- o_frame_done  out  1  one-cycle pulse at the closing boundary of a processed frame.
- o_frame_err  out  1  one-cycle pulse, coincident with o_frame_done, when the pixel count is not H_ACTIVE*V_ACTIVE.
- o_frame_cnt  out  FRAME_CNT_W  number of completed frames, wrapping.
- o_busy  out  1  high in S_RUN and S_DRAIN.

## Operation
- Boundary event B is combinational.
  - vs_d is i_VGA_VSYNC registered.
  - When VSYNC_ACTIVE_LOW=1: B = vs_d & ~i_VGA_VSYNC.
  - When VSYNC_ACTIVE_LOW=0: B = ~vs_d & i_VGA_VSYNC.
- States and transitions:
  - S_IDLE: if i_grayscale_start, go to S_ARM. Pixels are ignored.
  - S_ARM: if ~i_grayscale_start, go to S_IDLE (takes priority). Otherwise, if B, go to S_RUN, clear x/y/count and pulse o_frame_start. Pixels are ignored, including any pixel in the B cycle.
  - S_RUN, on B: pulse o_frame_done (plus o_frame_err if the count is wrong) and increment o_frame_cnt.
    - If i_grayscale_start is high: stay in S_RUN, clear the counters and pulse o_frame_start in the same cycle as o_frame_done.
    - If i_grayscale_start is low: go to S_IDLE.
  - S_RUN, ~i_grayscale_start without B: go to S_DRAIN. The current frame always completes.
  - S_DRAIN: on B, do the done/err/cnt actions as in S_RUN and go to S_IDLE. If i_grayscale_start reasserts without B, return to S_RUN with no counter disturbance.
- Pixel counting (S_RUN and S_DRAIN only):
  - Each i_pix_valid pixel is accepted unless the frame is already full.
  - x increments. When x is H_ACTIVE-1, x wraps to 0 and y increments.
  - The pixel at (H_ACTIVE-1, V_ACTIVE-1) sets the full flag.
  - A pixel arriving while full is not forwarded and sets the overflow flag.
  - A pixel in a B cycle belongs to the ending frame: it is counted and forwarded before the clear.
- o_frame_err = done & (~full | overflow).
  - full and overflow clear with the counters.
- Arithmetic:
  - x and y are 10-bit unsigned.
  - o_frame_cnt wraps modulo 2^FRAME_CNT_W.

## Timing
- Reset values: state S_IDLE, vs_d = 1 if VSYNC_ACTIVE_LOW else 0, and every output 0 (o_pix_x/o_pix_y 0, o_frame_cnt 0).
- Reset mid-frame aborts immediately with no done pulse, and the counters clear.
- All outputs are registered.
  - Pixel path: i_pix_valid accepted at edge N gives o_pix_en=1 during cycle N+1, with o_pix_x/o_pix_y holding that pixel's coordinates.
  - Frame pulses: a B cycle ending at edge N gives o_frame_start / o_frame_done / o_frame_err high for exactly cycle N+1. o_frame_cnt shows the new value from cycle N+1.
- First processed frame latency: 1 cycle after the first B following i_grayscale_start rising.
- Simultaneous events:
  - B with a start drop in S_RUN: the frame closes and the state goes to S_IDLE; there is no S_DRAIN cycle.
  - B with a start rise in S_IDLE: no action; the state goes to S_ARM, and the next B starts the frame.
- o_busy is registered from the state.

## Test plan
- H_ACTIVE=4, V_ACTIVE=3; start high, then a VSYNC falling edge, 12 valid pixels, then a second falling edge.
  - Response: o_frame_start 1 cycle after the first edge; o_pix_en 12 times with (x,y) running (0,0)..(3,2); o_frame_done 1 cycle after the second edge; o_frame_err=0; o_frame_cnt=1.
- Same setup, but only 11 pixels, then 13 pixels in the next frame.
  - Response: o_frame_err pulses on both dones; the 13th pixel gets no o_pix_en; o_frame_cnt=2.
- Start low mid-frame, after 5 pixels.
  - Response: the state goes to S_DRAIN, the remaining 7 pixels are forwarded, then at the edge o_frame_done=1, o_frame_start=0, and state S_IDLE with o_busy=0.
- Start continuous across 3 boundaries.
  - Response: each later boundary pulses o_frame_done and o_frame_start in the same cycle; o_frame_cnt goes 1, 2.
- Pixel coincident with B, and a pixel while in S_ARM.
  - Response: the B-cycle pixel is forwarded as (3,2) of the old frame; the S_ARM pixel is never forwarded.
- i_rst_n low mid-frame for 2 cycles.
  - Response: all outputs 0 immediately, no o_frame_done, and the state is S_IDLE after release.

Source files
------------

// File: rtl/blob_frame_sequencer_if.sv
// Pixel/frame bus between the sync controller, the frame sequencer and the
// grayscale/blob datapath.
//   i_grayscale_start : processing-enable level from the sync controller
//   i_VGA_VSYNC       : raw VGA vertical sync
//   i_pix_valid       : one active pixel presented this cycle
//   o_pix_en/x/y      : registered pixel accept and its coordinates
//   o_frame_start/done/err : one-cycle frame pulses
//   o_frame_cnt       : completed frames, wrapping
//   o_busy            : a frame window is open (running or draining)
// master = sync controller side (drives i_*), slave = the sequencer.
interface blob_frame_sequencer_if #(
    parameter int FRAME_CNT_W = 16
);
    logic                   i_grayscale_start;
    logic                   i_VGA_VSYNC;
    logic                   i_pix_valid;
    logic                   o_pix_en;
    logic [9:0]             o_pix_x;
    logic [9:0]             o_pix_y;
    logic                   o_frame_start;
    logic                   o_frame_done;
    logic                   o_frame_err;
    logic [FRAME_CNT_W-1:0] o_frame_cnt;
    logic                   o_busy;

    modport master (
        output i_grayscale_start, i_VGA_VSYNC, i_pix_valid,
        input  o_pix_en, o_pix_x, o_pix_y, o_frame_start, o_frame_done,
               o_frame_err, o_frame_cnt, o_busy
    );

    modport slave (
        input  i_grayscale_start, i_VGA_VSYNC, i_pix_valid,
        output o_pix_en, o_pix_x, o_pix_y, o_frame_start, o_frame_done,
               o_frame_err, o_frame_cnt, o_busy
    );
endinterface

// File: rtl/blob_frame_sequencer.sv
// Frame-aligned sequencer: turns the grayscale start level plus VSYNC into
// whole-frame processing windows, numbers accepted pixels with x/y and
// reports frame start/done/error and a completed-frame count.
// Ports: i_clk (pixel clock), i_rst_n (async, active-low), bus (slave side of
// blob_frame_sequencer_if, see that file for the signal list).
//
// state   | meaning
// S_IDLE  | processing disabled, pixels ignored
// S_ARM   | start seen, waiting for the next frame boundary
// S_RUN   | inside a frame, counting pixels
// S_DRAIN | start dropped, finishing the current frame
module blob_frame_sequencer #(
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int FRAME_CNT_W      = 16,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    blob_frame_sequencer_if.slave          bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t                 state_q, state_d;
    logic                   vs_q;
    logic [9:0]             x_q, x_d, y_q, y_d;
    logic                   full_q, full_d, ovf_q, ovf_d;
    logic                   pix_en_q, pix_en_d;
    logic [9:0]             pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic                   fs_q, fs_d, fd_q, fd_d, fe_q, fe_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   boundary, counting, clear;

    assign boundary = VSYNC_ACTIVE_LOW ? (vs_q & ~bus.i_VGA_VSYNC)
                                       : (~vs_q & bus.i_VGA_VSYNC);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        pix_en_d = 1'b0;
        pix_x_d  = pix_x_q;
        pix_y_d  = pix_y_q;
        fs_d     = 1'b0;
        fd_d     = 1'b0;
        fe_d     = 1'b0;
        cnt_d    = cnt_q;
        clear    = 1'b0;
        counting = (state_q == S_RUN) || (state_q == S_DRAIN);

        // Pixel accounting happens before the frame-close check so that a
        // pixel in the boundary cycle still belongs to the ending frame.
        if (counting && bus.i_pix_valid) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                pix_en_d = 1'b1;
                pix_x_d  = x_q;
                pix_y_d  = y_q;
                if (x_q == X_LAST) begin
                    x_d = 10'd0;
                    y_d = y_q + 10'd1;
                    if (y_q == Y_LAST) full_d = 1'b1;
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
        end

        if (counting && boundary) begin
            fd_d  = 1'b1;
            fe_d  = ~full_d | ovf_d;
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: if (bus.i_grayscale_start) state_d = S_ARM;
            S_ARM: begin
                if (!bus.i_grayscale_start) begin
                    state_d = S_IDLE;
                end else if (boundary) begin
                    state_d = S_RUN;
                    clear   = 1'b1;
                    fs_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (boundary) begin
                    if (bus.i_grayscale_start) begin
                        clear = 1'b1;
                        fs_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (!bus.i_grayscale_start) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (boundary) state_d = S_IDLE;
                else if (bus.i_grayscale_start) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            x_d    = 10'd0;
            y_d    = 10'd0;
            full_d = 1'b0;
            ovf_d  = 1'b0;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            vs_q     <= VSYNC_ACTIVE_LOW;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            pix_en_q <= 1'b0;
            pix_x_q  <= 10'd0;
            pix_y_q  <= 10'd0;
            fs_q     <= 1'b0;
            fd_q     <= 1'b0;
            fe_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= bus.i_VGA_VSYNC;
            x_q      <= x_d;
            y_q      <= y_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            pix_en_q <= pix_en_d;
            pix_x_q  <= pix_x_d;
            pix_y_q  <= pix_y_d;
            fs_q     <= fs_d;
            fd_q     <= fd_d;
            fe_q     <= fe_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.o_pix_en      = pix_en_q;
    assign bus.o_pix_x       = pix_x_q;
    assign bus.o_pix_y       = pix_y_q;
    assign bus.o_frame_start = fs_q;
    assign bus.o_frame_done  = fd_q;
    assign bus.o_frame_err   = fe_q;
    assign bus.o_frame_cnt   = cnt_q;
    assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_blob_frame_sequencer.sv
module tb_blob_frame_sequencer;
    localparam int H = 4;
    localparam int V = 3;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blob_frame_sequencer_if #(.FRAME_CNT_W(W)) bus();

    blob_frame_sequencer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_CNT_W(W), .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame window is either open or not; pixels are
    // numbered 0..H*V-1 within it and coordinates follow from the number.
    logic       m_in, m_arm, m_drain, m_ovf, m_vs, b;
    int         m_n, m_frames;
    logic       e_en, e_fs, e_fd, e_fe, e_busy;
    logic [9:0] e_x, e_y;
    logic [W-1:0] e_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in = 0; m_arm = 0; m_drain = 0; m_ovf = 0; m_vs = 1;
            m_n = 0; m_frames = 0;
            e_en = 0; e_fs = 0; e_fd = 0; e_fe = 0; e_busy = 0;
            e_x = 0; e_y = 0; e_cnt = 0;
        end else begin
            b = m_vs & ~bus.i_VGA_VSYNC;
            m_vs = bus.i_VGA_VSYNC;
            e_en = 0; e_fs = 0; e_fd = 0; e_fe = 0;
            if (m_in) begin
                if (bus.i_pix_valid) begin
                    if (m_n < H * V) begin
                        e_en = 1;
                        e_x = 10'(m_n % H);
                        e_y = 10'(m_n / H);
                        m_n++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (b) begin
                    e_fd = 1;
                    e_fe = (m_n != H * V) || m_ovf;
                    m_frames++;
                    if (bus.i_grayscale_start && !m_drain) begin
                        m_n = 0; m_ovf = 0; e_fs = 1;
                    end else begin
                        m_in = 0;
                    end
                end else begin
                    m_drain = !bus.i_grayscale_start;
                end
            end else if (m_arm) begin
                if (!bus.i_grayscale_start) m_arm = 0;
                else if (b) begin
                    m_arm = 0; m_in = 1; m_drain = 0; m_n = 0; m_ovf = 0; e_fs = 1;
                end
            end else if (bus.i_grayscale_start) begin
                m_arm = 1;
            end
            e_busy = m_in;
            e_cnt = W'(m_frames % (1 << W));
        end
    end

    int t_en = 0, t_fs = 0, t_fd = 0, t_fe = 0;
    logic [9:0] last_x = 0, last_y = 0;

    always @(negedge clk) begin
        chk("pix_en", 32'(bus.o_pix_en), 32'(e_en));
        if (e_en) begin
            chk("pix_x", 32'(bus.o_pix_x), 32'(e_x));
            chk("pix_y", 32'(bus.o_pix_y), 32'(e_y));
        end
        chk("frame_start", 32'(bus.o_frame_start), 32'(e_fs));
        chk("frame_done", 32'(bus.o_frame_done), 32'(e_fd));
        chk("frame_err", 32'(bus.o_frame_err), 32'(e_fe));
        chk("frame_cnt", 32'(bus.o_frame_cnt), 32'(e_cnt));
        chk("busy", 32'(bus.o_busy), 32'(e_busy));
        t_en += int'(bus.o_pix_en);
        t_fs += int'(bus.o_frame_start);
        t_fd += int'(bus.o_frame_done);
        t_fe += int'(bus.o_frame_err);
        if (bus.o_pix_en) begin
            last_x = bus.o_pix_x;
            last_y = bus.o_pix_y;
        end
    end

    task automatic step(input logic s, input logic vs, input logic pv);
        @(negedge clk);
        bus.i_grayscale_start = s;
        bus.i_VGA_VSYNC = vs;
        bus.i_pix_valid = pv;
    endtask

    task automatic pixels(input int n, input logic s);
        repeat (n) step(s, 1'b1, 1'b1);
    endtask

    task automatic boundary(input logic s, input logic pv);
        step(s, 1'b0, pv);
        step(s, 1'b1, 1'b0);
    endtask

    task automatic settle(input logic s);
        step(s, 1'b1, 1'b0);
        #1;
    endtask

    logic s_r;

    initial begin
        bus.i_grayscale_start = 0;
        bus.i_VGA_VSYNC = 1;
        bus.i_pix_valid = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(bus.o_busy), 0);
        chk("reset_cnt", 32'(bus.o_frame_cnt), 0);
        #1 rst_n = 1;

        // Complete 12-pixel frame
        step(1, 1, 0);
        boundary(1, 0);
        pixels(12, 1);
        boundary(1, 0);
        settle(1);
        chk("t1_en_total", t_en, 12);
        chk("t1_start_total", t_fs, 2);
        chk("t1_done_total", t_fd, 1);
        chk("t1_err_total", t_fe, 0);
        chk("t1_cnt", 32'(bus.o_frame_cnt), 1);
        chk("t1_last_x", 32'(last_x), 3);
        chk("t1_last_y", 32'(last_y), 2);

        // Short frame then overlong frame
        pixels(11, 1);
        boundary(1, 0);
        pixels(13, 1);
        boundary(1, 0);
        settle(1);
        chk("t2_err_total", t_fe, 2);
        chk("t2_en_total", t_en, 35);
        chk("t2_cnt", 32'(bus.o_frame_cnt), 3);

        // Last pixel arrives in the boundary cycle
        pixels(11, 1);
        boundary(1, 1);
        settle(1);
        chk("t3_err_total", t_fe, 2);
        chk("t3_en_total", t_en, 47);
        chk("t3_last_x", 32'(last_x), 3);
        chk("t3_last_y", 32'(last_y), 2);

        // Start drops mid-frame: frame drains and closes
        pixels(5, 1);
        pixels(7, 0);
        #1 chk("t4_busy_drain", 32'(bus.o_busy), 1);
        boundary(0, 0);
        settle(0);
        chk("t4_busy_after", 32'(bus.o_busy), 0);
        chk("t4_done_total", t_fd, 5);
        chk("t4_start_total", t_fs, 5);
        chk("t4_en_total", t_en, 59);

        // Pixels while idle/armed are never forwarded
        step(1, 1, 1);
        step(1, 1, 1);
        boundary(1, 1);
        settle(1);
        chk("t5_en_total", t_en, 59);
        chk("t5_start_total", t_fs, 6);

        // Reset mid-frame
        pixels(3, 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_pix_en", 32'(bus.o_pix_en), 0);
        chk("rst_done", 32'(bus.o_frame_done), 0);
        chk("rst_cnt", 32'(bus.o_frame_cnt), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        step(1, 1, 0);
        settle(1);
        chk("rst_busy_after", 32'(bus.o_busy), 0);
        chk("rst_done_total", t_fd, 5);

        // Randomized traffic
        s_r = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) s_r = ~s_r;
            step(s_r, $urandom_range(0, 13) != 0, $urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
